// File: rtl/pipe_bshifter_if.sv
// ---------------------------------------------------------------------------
// pipe_bshifter_if
//   Operation and result channels of the pipelined barrel shifter.
//   Input channel  : in_valid/in_ready handshake with operand, shift amount,
//                    mode and sideband tag.
//   Output channel : out_valid/out_ready handshake with result and tag.
//   Modports       : master = producer of operations / consumer of results,
//                    slave  = the shifter itself.
// ---------------------------------------------------------------------------
interface pipe_bshifter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 5
);
  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [SHAMT_W-1:0]    in_shamt;
  logic [2:0]            in_mode;
  logic [TAG_W-1:0]      in_tag;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_W-1:0]      out_tag;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipe_bshifter.sv
// ---------------------------------------------------------------------------
// pipe_bshifter
//   Pipelined barrel shifter / rotator (SLL, SRL, SRA, ROL, ROR).
//   The log2(DATA_WIDTH) shift levels are spread over PIPE_STAGES register
//   stages; all stages advance together under a single valid/ready stall.
// Ports
//   clk   : clock, rising edge
//   rst   : synchronous reset, active-high (empties pipe, zeroes outputs)
//   flush : synchronous pipeline kill, active-high (drops all ops in flight
//           and any op offered in the same cycle)
//   bus   : pipe_bshifter_if.slave (operation in, result out)
// ---------------------------------------------------------------------------
module pipe_bshifter #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  pipe_bshifter_if.slave bus
);
  localparam int SHAMT_W       = $clog2(DATA_WIDTH);
  localparam int LVL_PER_STAGE = (SHAMT_W + PIPE_STAGES - 1) / PIPE_STAGES;

  typedef enum logic [2:0] {
    MODE_SLL = 3'b000,
    MODE_SRL = 3'b001,
    MODE_SRA = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100
  } mode_e;

  // Everything an operation needs to finish its remaining levels travels
  // with it; sign is the original operand MSB, so SRA fill stays correct
  // after earlier levels have already shifted the data.
  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic [SHAMT_W-1:0]    shamt;
    logic [2:0]            mode;
    logic                  sign;
    logic [TAG_W-1:0]      tag;
  } stage_t;

  // First shift level handled by stage s.
  function automatic int lvl_lo(input int s);
    return s * LVL_PER_STAGE;
  endfunction

  // One past the last level handled by stage s; the last stage absorbs any
  // levels left over, earlier stages may end up with fewer than the quota.
  function automatic int lvl_hi(input int s);
    int hi;
    hi = (s + 1) * LVL_PER_STAGE;
    if (s == PIPE_STAGES - 1 || hi > SHAMT_W) hi = SHAMT_W;
    return hi;
  endfunction

  // Single level k: shift/rotate by 2**k according to mode.
  function automatic logic [DATA_WIDTH-1:0] shift_level(
    input logic [DATA_WIDTH-1:0] d,
    input int                    k,
    input logic [2:0]            mode,
    input logic                  sign
  );
    logic [DATA_WIDTH-1:0] res;
    logic [DATA_WIDTH-1:0] fill;
    int                    amt;
    amt  = 1 << k;
    fill = sign ? ~({DATA_WIDTH{1'b1}} >> amt) : '0;
    case (mode)
      MODE_SLL: res = d << amt;
      MODE_SRL: res = d >> amt;
      MODE_SRA: res = (d >> amt) | fill;
      MODE_ROL: res = (d << amt) | (d >> (DATA_WIDTH - amt));
      MODE_ROR: res = (d >> amt) | (d << (DATA_WIDTH - amt));
      default:  res = d;  // reserved modes pass the operand through
    endcase
    return res;
  endfunction

  logic adv;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    stage_t src;
    stage_t stage_d;
    stage_t stage_q;

    if (s == 0) begin : g_in
      assign src.valid = bus.in_valid;
      assign src.data  = bus.in_data;
      assign src.shamt = bus.in_shamt;
      assign src.mode  = bus.in_mode;
      assign src.sign  = bus.in_data[DATA_WIDTH-1];
      assign src.tag   = bus.in_tag;
    end else begin : g_chain
      assign src = g_stage[s-1].stage_q;
    end

    always_comb begin
      // NOTE: stage_d takes a full default before the conditional updates,
      // so no path leaves it unassigned and no latch is inferred.
      stage_d = src;
      for (int k = lvl_lo(s); k < lvl_hi(s); k++) begin
        if (src.shamt[k]) begin
          stage_d.data = shift_level(stage_d.data, k, src.mode, src.sign);
        end
      end
    end

    always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its predecessor's pre-edge value regardless of process order.
      if (rst) begin
        // NOTE: the datapath is reset too, not just valid, because the
        // output data/tag must read zero after reset.
        stage_q <= '0;
      end else if (flush) begin
        stage_q.valid <= 1'b0;
      end else if (adv) begin
        stage_q <= stage_d;
      end
    end
  end

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv           = !g_stage[PIPE_STAGES-1].stage_q.valid || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = g_stage[PIPE_STAGES-1].stage_q.valid;
  assign bus.out_data  = g_stage[PIPE_STAGES-1].stage_q.data;
  assign bus.out_tag   = g_stage[PIPE_STAGES-1].stage_q.tag;

endmodule

// File: tb/tb_pipe_bshifter.sv
// ---------------------------------------------------------------------------
// tb_pipe_bshifter
//   Self-checking bench for pipe_bshifter (32-bit, 2 stages, 5-bit tag).
//   Vectors table + scoreboard queue, plus hand-written stall/flush/reset
//   sequences.
// ---------------------------------------------------------------------------
module tb_pipe_bshifter;
  localparam int DW = 32;
  localparam int PS = 2;
  localparam int TW = 5;
  localparam int SW = $clog2(DW);

  localparam logic [2:0] SLL = 3'b000;
  localparam logic [2:0] SRL = 3'b001;
  localparam logic [2:0] SRA = 3'b010;
  localparam logic [2:0] ROL = 3'b011;
  localparam logic [2:0] ROR = 3'b100;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  pipe_bshifter_if #(.DATA_WIDTH(DW), .TAG_W(TW)) bus ();

  pipe_bshifter #(.DATA_WIDTH(DW), .PIPE_STAGES(PS), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] shamt;
    logic [2:0]    mode;
    logic [TW-1:0] tag;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t offer_exp;
  int   xfer_cyc[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic [SW-1:0] sh, input logic [2:0] m,
                       input logic [TW-1:0] t, input logic [DW-1:0] e);
    bus.in_valid   = 1'b1;
    bus.in_data    = d;
    bus.in_shamt   = sh;
    bus.in_mode    = m;
    bus.in_tag     = t;
    offer_exp.data = e;
    offer_exp.tag  = t;
  endtask

  // Called at a negedge with inputs already set: samples the handshakes
  // that will take effect at the coming posedge, updates the scoreboard,
  // then moves on to the next negedge.
  task automatic cycle();
    exp_t e;
    #1;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      xfer_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got tag %0h data %0h, want no output", bus.out_tag, bus.out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", 64'(bus.out_data), 64'(e.data));
        check("out_tag", 64'(bus.out_tag), 64'(e.tag));
      end
    end
    if (rst || flush) sb.delete();
    else if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) sb.push_back(offer_exp);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 3; i++) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int base;

    vecs[0]  = '{32'h0000_0001, 5'd31, SLL, 5'd3,  32'h8000_0000};
    vecs[1]  = '{32'h8000_0000, 5'd4,  SRA, 5'd1,  32'hF800_0000};
    vecs[2]  = '{32'h8000_0000, 5'd4,  SRL, 5'd2,  32'h0800_0000};
    vecs[3]  = '{32'h1234_5678, 5'd8,  ROR, 5'd4,  32'h7812_3456};
    vecs[4]  = '{32'h1234_5678, 5'd8,  ROL, 5'd5,  32'h3456_7812};
    vecs[5]  = '{32'h1234_5678, 5'd0,  ROL, 5'd6,  32'h1234_5678};
    vecs[6]  = '{32'h7FFF_0000, 5'd16, SRA, 5'd7,  32'h0000_7FFF};
    vecs[7]  = '{32'hDEAD_BEEF, 5'd7,  3'd5, 5'd8, 32'hDEAD_BEEF};
    vecs[8]  = '{32'hF000_0001, 5'd1,  SLL, 5'd9,  32'hE000_0002};
    vecs[9]  = '{32'h0000_0001, 5'd1,  ROR, 5'd10, 32'h8000_0000};
    vecs[10] = '{32'hFFFF_FFF0, 5'd31, SRA, 5'd11, 32'hFFFF_FFFF};
    vecs[11] = '{32'h1234_5678, 5'd0,  SRL, 5'd12, 32'h1234_5678};
    vecs[12] = '{32'h8000_0001, 5'd31, ROL, 5'd13, 32'hC000_0000};
    vecs[13] = '{32'h8000_0000, 5'd31, SRA, 5'd14, 32'hFFFF_FFFF};
    vecs[14] = '{32'h0F0F_0F0F, 5'd3,  3'd7, 5'd15, 32'h0F0F_0F0F};

    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_shamt = '0;
    bus.in_mode = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    offer_exp = '{'0, '0};
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single op latency.
    offer(32'h0000_0001, 5'd31, SLL, 5'd3, 32'h8000_0000);
    cycle();
    bus.in_valid = 1'b0;
    lat = 1;
    #1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      cycle();
      lat++;
      #1;
    end
    check("sll_latency", 64'(lat), 64'(PS));
    drain(20);

    // Table vectors, streamed back to back.
    for (int i = 0; i < 15; i++) begin
      offer(vecs[i].data, vecs[i].shamt, vecs[i].mode, vecs[i].tag, vecs[i].exp);
      cycle();
    end
    drain(40);

    // Eight back-to-back ops, tags 0..7: consecutive in-order outputs.
    base = xfer_cyc.size();
    for (int i = 0; i < 8; i++) begin
      offer(32'h0000_00A5 + DW'(i), SW'(i), SLL, TW'(i), (32'h0000_00A5 + DW'(i)) << i);
      cycle();
    end
    drain(40);
    check("stream_count", 64'(xfer_cyc.size() - base), 64'd8);
    if (xfer_cyc.size() - base == 8)
      check("stream_span", 64'(xfer_cyc[base+7] - xfer_cyc[base]), 64'd7);

    // Stall: three ops offered, consumer blocks for five cycles.
    base = xfer_cyc.size();
    bus.out_ready = 1'b0;
    offer(32'h0000_00F0, 5'd4, SRL, 5'd20, 32'h0000_000F);
    cycle();
    offer(32'h0000_0003, 5'd2, ROR, 5'd21, 32'hC000_0000);
    cycle();
    offer(32'h8000_00FF, 5'd8, SRA, 5'd22, 32'hFF80_0000);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      check("stall_out_valid", 64'(bus.out_valid), 64'd1);
      check("stall_out_data", 64'(bus.out_data), 64'(sb[0].data));
      check("stall_out_tag", 64'(bus.out_tag), 64'(sb[0].tag));
      cycle();
    end
    bus.out_ready = 1'b1;
    cycle();
    drain(20);
    check("stall_delivered", 64'(xfer_cyc.size() - base), 64'd3);

    // Flush with two ops in flight plus one offered in the flush cycle.
    base = xfer_cyc.size();
    bus.out_ready = 1'b0;
    offer(32'h0000_1111, 5'd1, SLL, 5'd24, 32'h0000_2222);
    cycle();
    offer(32'h0000_2222, 5'd1, SLL, 5'd25, 32'h0000_4444);
    cycle();
    offer(32'h0000_3333, 5'd1, SLL, 5'd26, 32'h0000_6666);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    drain(10);
    check("flush_no_emerge", 64'(xfer_cyc.size() - base), 64'd0);
    offer(32'h0000_0100, 5'd8, ROR, 5'd27, 32'h0000_0001);
    cycle();
    drain(20);
    check("post_flush_op", 64'(xfer_cyc.size() - base), 64'd1);

    // Same again, killed by reset instead of flush.
    base = xfer_cyc.size();
    bus.out_ready = 1'b0;
    offer(32'hAAAA_0000, 5'd16, ROL, 5'd28, 32'h0000_AAAA);
    cycle();
    offer(32'h5555_0000, 5'd16, ROR, 5'd29, 32'h0000_5555);
    cycle();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst2_out_data", 64'(bus.out_data), 64'd0);
    check("rst2_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst2_in_ready", 64'(bus.in_ready), 64'd1);
    drain(10);
    check("rst_no_emerge", 64'(xfer_cyc.size() - base), 64'd0);
    offer(32'h0000_0001, 5'd5, SLL, 5'd30, 32'h0000_0020);
    cycle();
    drain(20);
    check("post_rst_op", 64'(xfer_cyc.size() - base), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
